// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the MIPS core: instruction field widths and the
// hazard controller's FSM state encoding.
package hazard_ctrl_pkg;

  localparam int OPCODE_W = 6;
  localparam int FUNCT_W  = 6;
  localparam int JUMP_W   = 26;

  localparam int HZ_STATE_W = 2;

  // The state records which action the controller took in the previous cycle.
  typedef enum logic [HZ_STATE_W-1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_FLUSH    = 2'd2,
    HZ_MEM_WAIT = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter. Stops at all-ones and never wraps.
// The rst input is synchronous and active-low, like the rest of the core.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/JAL flushes, memory
// backpressure freeze, performance counters and a sticky memory-timeout flag.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int AWIDTH  = 5,
  parameter int CWIDTH  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              hz_clk,
  input  logic              hz_rst,
  input  logic              hz_i_ce,
  input  logic [AWIDTH-1:0] hz_i_rs,
  input  logic [AWIDTH-1:0] hz_i_rt,
  input  logic              hz_i_uses_rt,
  input  logic              hz_i_ex_memread,
  input  logic [AWIDTH-1:0] hz_i_ex_rt,
  input  logic              hz_i_jal,
  input  logic              hz_i_br_taken,
  input  logic              hz_i_mem_busy,
  output logic              hz_o_pc_en,
  output logic              hz_o_ifid_en,
  output logic              hz_o_ifid_flush,
  output logic              hz_o_idex_flush,
  output logic              hz_o_exmem_en,
  output logic [1:0]        hz_o_state,
  output logic [CWIDTH-1:0] hz_o_stall_cnt,
  output logic [CWIDTH-1:0] hz_o_flush_cnt,
  output logic              hz_o_err
);

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;

  hz_state_e         state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              err_reg, err_next;
  logic              lu_hazard;
  logic              stall_inc;
  logic              flush_inc;

  // Register $0 is never a real dependency; rt only matters if decode reads it.
  assign lu_hazard = hz_i_ex_memread && (hz_i_ex_rt != '0) &&
                     ((hz_i_ex_rt == hz_i_rs) ||
                      (hz_i_uses_rt && (hz_i_ex_rt == hz_i_rt)));

  always_comb begin
    hz_o_pc_en      = 1'b0;
    hz_o_ifid_en    = 1'b0;
    hz_o_ifid_flush = 1'b0;
    hz_o_idex_flush = 1'b0;
    hz_o_exmem_en   = 1'b0;
    state_next      = state_reg;
    wait_cnt_next   = wait_cnt_reg;
    err_next        = err_reg;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;

    if (!hz_i_mem_busy) begin
      wait_cnt_next = '0;
    end

    if (hz_rst && hz_i_ce) begin
      hz_o_pc_en    = 1'b1;
      hz_o_ifid_en  = 1'b1;
      hz_o_exmem_en = 1'b1;
      // Priority order matters: a frozen pipeline defers every other event,
      // and a taken branch squashes the decode slot holding a JAL or hazard.
      if (hz_i_mem_busy) begin
        hz_o_pc_en    = 1'b0;
        hz_o_ifid_en  = 1'b0;
        hz_o_exmem_en = 1'b0;
        state_next    = HZ_MEM_WAIT;
        if (wait_cnt_reg != '1) begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
        if (wait_cnt_reg >= WAIT_W'(TIMEOUT - 1)) begin
          err_next = 1'b1;
        end
      end else if (hz_i_br_taken) begin
        hz_o_ifid_flush = 1'b1;
        hz_o_idex_flush = 1'b1;
        state_next      = HZ_FLUSH;
        flush_inc       = 1'b1;
      end else if (lu_hazard) begin
        hz_o_pc_en      = 1'b0;
        hz_o_ifid_en    = 1'b0;
        hz_o_idex_flush = 1'b1;
        state_next      = HZ_LU_STALL;
        stall_inc       = 1'b1;
      end else if (hz_i_jal) begin
        hz_o_ifid_flush = 1'b1;
        state_next      = HZ_FLUSH;
        flush_inc       = 1'b1;
      end else begin
        state_next = HZ_RUN;
      end
    end
  end

  always_ff @(posedge hz_clk) begin
    if (!hz_rst) begin
      state_reg    <= HZ_RUN;
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
    end
  end

  sat_counter #(.WIDTH(CWIDTH)) u_stall_cnt (
    .clk   (hz_clk),
    .rst   (hz_rst),
    .inc   (stall_inc),
    .count (hz_o_stall_cnt)
  );

  sat_counter #(.WIDTH(CWIDTH)) u_flush_cnt (
    .clk   (hz_clk),
    .rst   (hz_rst),
    .inc   (flush_inc),
    .count (hz_o_flush_cnt)
  );

  assign hz_o_state = state_reg;
  assign hz_o_err   = err_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan scenarios followed by
// randomized traffic, each cycle checked against a behavioural model.
module tb_hazard_ctrl;

  localparam int AWIDTH  = 5;
  localparam int CWIDTH  = 2;
  localparam int TIMEOUT = 4;
  localparam int CMAX    = (1 << CWIDTH) - 1;

  logic              hz_clk = 1'b0;
  logic              hz_rst;
  logic              hz_i_ce;
  logic [AWIDTH-1:0] hz_i_rs;
  logic [AWIDTH-1:0] hz_i_rt;
  logic              hz_i_uses_rt;
  logic              hz_i_ex_memread;
  logic [AWIDTH-1:0] hz_i_ex_rt;
  logic              hz_i_jal;
  logic              hz_i_br_taken;
  logic              hz_i_mem_busy;
  logic              hz_o_pc_en;
  logic              hz_o_ifid_en;
  logic              hz_o_ifid_flush;
  logic              hz_o_idex_flush;
  logic              hz_o_exmem_en;
  logic [1:0]        hz_o_state;
  logic [CWIDTH-1:0] hz_o_stall_cnt;
  logic [CWIDTH-1:0] hz_o_flush_cnt;
  logic              hz_o_err;

  hazard_ctrl #(.AWIDTH(AWIDTH), .CWIDTH(CWIDTH), .TIMEOUT(TIMEOUT)) dut (
    .hz_clk          (hz_clk),
    .hz_rst          (hz_rst),
    .hz_i_ce         (hz_i_ce),
    .hz_i_rs         (hz_i_rs),
    .hz_i_rt         (hz_i_rt),
    .hz_i_uses_rt    (hz_i_uses_rt),
    .hz_i_ex_memread (hz_i_ex_memread),
    .hz_i_ex_rt      (hz_i_ex_rt),
    .hz_i_jal        (hz_i_jal),
    .hz_i_br_taken   (hz_i_br_taken),
    .hz_i_mem_busy   (hz_i_mem_busy),
    .hz_o_pc_en      (hz_o_pc_en),
    .hz_o_ifid_en    (hz_o_ifid_en),
    .hz_o_ifid_flush (hz_o_ifid_flush),
    .hz_o_idex_flush (hz_o_idex_flush),
    .hz_o_exmem_en   (hz_o_exmem_en),
    .hz_o_state      (hz_o_state),
    .hz_o_stall_cnt  (hz_o_stall_cnt),
    .hz_o_flush_cnt  (hz_o_flush_cnt),
    .hz_o_err        (hz_o_err)
  );

  always #5 hz_clk = ~hz_clk;

  typedef struct {
    int txn;
    bit pc_en, ifid_en, ifid_flush, idex_flush, exmem_en;
    int state, stall, flush;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   txn_id = 0;

  // Reference model: action-level view of the controller.
  int m_state = 0, m_stall = 0, m_flush = 0, m_busy_run = 0;
  bit m_err = 0;

  task automatic chk(input string name, input int txn, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s txn=%0d actual=%0d required=%0d", name, txn, act, req);
    end
  endtask

  task automatic step(input bit rst, input bit ce, input int rs, input int rt,
                      input bit uses_rt, input bit memread, input int ex_rt,
                      input bit jal, input bit br, input bit busy);
    exp_t e;
    bit   lu;
    @(posedge hz_clk);
    #1;
    hz_rst = rst; hz_i_ce = ce;
    hz_i_rs = AWIDTH'(rs); hz_i_rt = AWIDTH'(rt); hz_i_uses_rt = uses_rt;
    hz_i_ex_memread = memread; hz_i_ex_rt = AWIDTH'(ex_rt);
    hz_i_jal = jal; hz_i_br_taken = br; hz_i_mem_busy = busy;

    lu = memread && ex_rt != 0 && (ex_rt == rs || (uses_rt && ex_rt == rt));
    e.txn = txn_id; txn_id++;
    e.state = m_state; e.stall = m_stall; e.flush = m_flush; e.err = m_err;
    {e.pc_en, e.ifid_en, e.ifid_flush, e.idex_flush, e.exmem_en} = 5'b00000;
    if (rst && ce) begin
      if (busy)     {e.pc_en, e.ifid_en, e.ifid_flush, e.idex_flush, e.exmem_en} = 5'b00000;
      else if (br)  {e.pc_en, e.ifid_en, e.ifid_flush, e.idex_flush, e.exmem_en} = 5'b11111;
      else if (lu)  {e.pc_en, e.ifid_en, e.ifid_flush, e.idex_flush, e.exmem_en} = 5'b00011;
      else if (jal) {e.pc_en, e.ifid_en, e.ifid_flush, e.idex_flush, e.exmem_en} = 5'b11101;
      else          {e.pc_en, e.ifid_en, e.ifid_flush, e.idex_flush, e.exmem_en} = 5'b11001;
    end
    exp_q.push_back(e);
    $display("txn=%0d rst=%0d ce=%0d rs=%0d rt=%0d urt=%0d mr=%0d exrt=%0d jal=%0d br=%0d busy=%0d",
             e.txn, rst, ce, rs, rt, uses_rt, memread, ex_rt, jal, br, busy);

    // Advance the model across the coming edge.
    if (!rst) begin
      m_state = 0; m_stall = 0; m_flush = 0; m_busy_run = 0; m_err = 0;
    end else begin
      if (!busy) m_busy_run = 0;
      if (ce) begin
        if (busy) begin
          m_state = 3;
          m_busy_run++;
          if (m_busy_run >= TIMEOUT) m_err = 1;
        end else if (br || (!lu && jal)) begin
          m_state = 2;
          if (m_flush < CMAX) m_flush++;
        end else if (lu) begin
          m_state = 1;
          if (m_stall < CMAX) m_stall++;
        end else begin
          m_state = 0;
        end
      end
    end
  endtask

  task automatic idle();
    step(1, 1, 1, 2, 1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: the DUT presents a response every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge hz_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_en",      e.txn, int'(hz_o_pc_en),      int'(e.pc_en));
        chk("ifid_en",    e.txn, int'(hz_o_ifid_en),    int'(e.ifid_en));
        chk("ifid_flush", e.txn, int'(hz_o_ifid_flush), int'(e.ifid_flush));
        chk("idex_flush", e.txn, int'(hz_o_idex_flush), int'(e.idex_flush));
        chk("exmem_en",   e.txn, int'(hz_o_exmem_en),   int'(e.exmem_en));
        chk("state",      e.txn, int'(hz_o_state),      e.state);
        chk("stall_cnt",  e.txn, int'(hz_o_stall_cnt),  e.stall);
        chk("flush_cnt",  e.txn, int'(hz_o_flush_cnt),  e.flush);
        chk("err",        e.txn, int'(hz_o_err),        int'(e.err));
      end
    end
  end

  initial begin
    int burst = 0;
    bit busy, ce, rst;
    hz_rst = 1'b0; hz_i_ce = 1'b1; hz_i_rs = '0; hz_i_rt = '0; hz_i_uses_rt = 1'b0;
    hz_i_ex_memread = 1'b0; hz_i_ex_rt = '0; hz_i_jal = 1'b0; hz_i_br_taken = 1'b0;
    hz_i_mem_busy = 1'b0;
    repeat (2) @(posedge hz_clk);

    // Reset state, with a hazard present to show outputs are forced off.
    step(0, 1, 2, 3, 1, 1, 3, 0, 0, 0);
    idle();
    // Load-use on rt, then the load moves on.
    step(1, 1, 2, 3, 1, 1, 3, 0, 0, 0);
    step(1, 1, 2, 3, 1, 0, 3, 0, 0, 0);
    // $0 and uses_rt guards.
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 5, 0, 1, 5, 0, 0, 0);
    // Branch + JAL + load-use together, then JAL alone.
    step(1, 1, 3, 0, 0, 1, 3, 1, 1, 0);
    idle();
    step(1, 1, 1, 2, 0, 0, 0, 1, 0, 0);
    idle();
    // Memory timeout, recovery, and reset clearing err.
    repeat (4) step(1, 1, 1, 2, 0, 0, 0, 0, 0, 1);
    idle();
    idle();
    step(0, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    idle();
    // Busy for TIMEOUT-1 cycles only: no error.
    repeat (3) step(1, 1, 1, 2, 0, 0, 0, 0, 0, 1);
    idle();
    // Stall counter saturation.
    repeat (5) step(1, 1, 4, 0, 0, 1, 4, 0, 0, 0);
    idle();
    // ce=0 during load-use.
    step(1, 0, 4, 0, 0, 1, 4, 0, 0, 0);
    idle();
    // Reset mid-MEM_WAIT.
    repeat (2) step(1, 1, 1, 2, 0, 0, 0, 1, 1, 1);
    step(0, 1, 1, 2, 0, 0, 0, 0, 0, 1);
    idle();
    idle();

    for (int i = 0; i < 400; i++) begin
      if (burst > 0) begin
        busy = 1; burst--;
      end else begin
        busy = 0;
        if ($urandom_range(0, 7) == 0) burst = $urandom_range(1, 6);
      end
      rst = ($urandom_range(0, 49) != 0);
      ce  = ($urandom_range(0, 9) != 0);
      step(rst, ce, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), busy);
    end

    repeat (3) @(negedge hz_clk);
    chk("queue_drained", txn_id, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core, sitting beside the decoder stage. It inspects the instruction in decode against the load in execute, taken branches, JAL and data-memory backpressure. From those it drives the PC, IF/ID, ID/EX and EX/MEM enables and flushes. It also keeps saturating stall and flush counters and a sticky memory-timeout error.

## Interface
- AWIDTH, 5, register address width
- CWIDTH, 16, width of each performance counter
- TIMEOUT, 64, consecutive mem-busy cycles that set the error flag (≥2)
- hz_clk  input  1  clock, all state updates on rising edge
- hz_rst  input  1  reset, synchronous, active-low
- hz_i_ce  input  1  controller enable
- hz_i_rs  input  AWIDTH  rs field of instruction in decode
- hz_i_rt  input  AWIDTH  rt field of instruction in decode
- hz_i_uses_rt  input  1  decode instruction reads rt (R-type, store, branch)
- hz_i_ex_memread  input  1  instruction in execute is a load
- hz_i_ex_rt  input  AWIDTH  destination register of that load
- hz_i_jal  input  1  decode instruction is JAL
- hz_i_br_taken  input  1  branch resolved taken in execute
- hz_i_mem_busy  input  1  data memory not ready
- hz_o_pc_en  output  1  PC register load enable
- hz_o_ifid_en  output  1  IF/ID register load enable
- hz_o_ifid_flush  output  1  IF/ID register clear to NOP
- hz_o_idex_flush  output  1  ID/EX register clear to bubble
- hz_o_exmem_en  output  1  EX/MEM register load enable
- hz_o_state  output  2  current FSM state
- hz_o_stall_cnt  output  CWIDTH  load-use stall cycles
- hz_o_flush_cnt  output  CWIDTH  control-flow flush events
- hz_o_err  output  1  sticky memory-timeout flag

## Operation
- States: RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3. The state records the action taken in the previous cycle.
- Control outputs are combinational (Mealy) from inputs. Counters, state and err are registered.
- Load-use hazard condition (LU): hz_i_ex_memread && hz_i_ex_rt != 0 && (hz_i_ex_rt == hz_i_rs || (hz_i_uses_rt && hz_i_ex_rt == hz_i_rt)).
- Defaults with ce=1: pc_en=1, ifid_en=1, exmem_en=1, both flushes 0.
- Each cycle with ce=1 and rst=1, the first matching rule applies:
  - Rule 1, mem_busy: pc_en=ifid_en=exmem_en=0, no flushes. Next state MEM_WAIT. wait counter +1.
  - Rule 2, br_taken: ifid_flush=1, idex_flush=1. Next state FLUSH. flush_cnt +1.
  - Rule 3, LU: pc_en=0, ifid_en=0, idex_flush=1. Next state LU_STALL. stall_cnt +1.
  - Rule 4, jal: ifid_flush=1. Next state FLUSH. flush_cnt +1.
  - Rule 5, otherwise: next state RUN.
- The wait counter is internal, log2(TIMEOUT)+1 bits wide. It clears whenever mem_busy=0. When it reaches TIMEOUT-1 while mem_busy=1, err is set and held until reset. The wait counter saturates.
- Branch and JAL arriving together: the branch wins. The JAL sits in the wrong-path decode slot and is flushed.
- Branch arriving with LU: the branch wins, because flushing decode removes the hazard.
- Events present during mem_busy are not lost. The pipeline is frozen, so they are re-evaluated once busy drops.
- hz_i_ce=0: all enables 0, flushes 0. State, counters and err hold. mem_busy is not counted.
- Performance counters saturate at all-ones and never wrap.

## Timing
- Reset (hz_rst=0 at a rising edge): state=RUN, both counters 0, wait counter 0, err=0.
- While hz_rst=0, outputs are forced: all enables 0, flushes 0.
- Reset mid-stall or mid-wait aborts immediately. There is no residual stall after reset releases.
- Control outputs respond in the same cycle as the inputs, with zero latency.
- Counters, state and err update at the next edge, so they show one cycle of latency.
- A load-use stall lasts exactly one cycle. The next cycle the load has moved to MEM, so ex_memread deasserts and no further stall occurs.
- With TIMEOUT=64, err rises at the edge ending the 64th consecutive busy cycle.

## Structure
- State encodings (RUN/LU_STALL/FLUSH/MEM_WAIT) and the state width go in the shared defines header, alongside the existing opcode/funct/jump width defines.
- One sub-module: sat_counter (parameter WIDTH; ports clk, rst, inc, count). It is instantiated twice, for the stall and flush counters.
- The FSM, hazard comparator and timeout logic live in hazard_ctrl itself.

## Test plan
- LU on rt: ex_memread=1, ex_rt=3, decode rs=2, rt=3, uses_rt=1.
  - Same cycle: pc_en=0, ifid_en=0, idex_flush=1.
  - Next edge: state=1, stall_cnt=1.
  - Then ex_memread=0 gives pc_en=1.
- $0 and uses_rt guards:
  - ex_rt=0 with rs=0 gives no stall.
  - ex_rt=5, rt=5, uses_rt=0 gives no stall.
- Branch + JAL + LU together: br_taken=1, jal=1, LU true.
  - Response: ifid_flush=1, idex_flush=1, pc_en=1.
  - Counters: flush_cnt +1 only, stall_cnt unchanged. state=2.
- JAL alone: ifid_flush=1, idex_flush=0, pc_en=1, flush_cnt=1.
- Memory timeout (TIMEOUT=4): mem_busy high for 4 cycles.
  - All enables 0 throughout. err=1 after the 4th edge.
  - busy drops: enables return to 1 and err stays 1.
  - Reset clears err.
- Saturation and ce (CWIDTH=2):
  - Four load-use stalls: stall_cnt=3, then holds.
  - ce=0 during LU: enables 0, no flush, count unchanged.
  - Reset asserted mid-MEM_WAIT: state=0, counters 0.
